// File: rtl/rom_pkg.sv
// Shared constants and types for the boot-ROM read-port arbiter.
package rom_pkg;
  localparam int          RSP_W        = 32;
  localparam logic [31:0] ROM_BASE_DEF = 32'hBFC0_0000;
  localparam int          ROM_SIZE_DEF = 4096;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic [RSP_W-1:0] data;
    logic             err;
  } rom_rsp_t;
endpackage

// File: rtl/rom_rsp_slot.sv
// One-entry response register; a full slot may be reloaded in the cycle its consumer drains it.
module rom_rsp_slot
  import rom_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              rsp_ready,
  output logic              free,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  logic              vld_p1, vld_p1_d;
  logic [DATA_W-1:0] data_p1, data_p1_d;
  logic              err_p1, err_p1_d;

  always_comb begin
    vld_p1_d  = vld_p1;
    data_p1_d = data_p1;
    err_p1_d  = err_p1;
    if (vld_p1 && rsp_ready) begin
      vld_p1_d = 1'b0;
    end
    if (load) begin
      vld_p1_d  = 1'b1;
      data_p1_d = load_data;
      err_p1_d  = load_err;
    end
  end

  // Stage 1: registered response, cleared entirely on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= vld_p1_d;
      data_p1 <= data_p1_d;
      err_p1  <= err_p1_d;
    end
  end

  assign free      = !vld_p1 || rsp_ready;
  assign rsp_valid = vld_p1;
  assign rsp_data  = data_p1;
  assign rsp_err   = err_p1;

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single combinational ROM read port between fetch and data requesters.
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = ROM_BASE_DEF,
  parameter int                       ROM_SIZE      = ROM_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_req_valid,
  output logic                     f_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] f_req_addr,
  output logic                     f_rsp_valid,
  input  logic                     f_rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] f_rsp_data,
  output logic                     f_rsp_err,
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] d_req_addr,
  output logic                     d_rsp_valid,
  input  logic                     d_rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] d_rsp_data,
  output logic                     d_rsp_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [ADDRESS_WIDTH-1:0] rom_dout
);

  // Last byte address at which a full 4-byte word still lies inside the window.
  localparam logic [ADDRESS_WIDTH-1:0] ROM_LAST = ROM_BASE + ADDRESS_WIDTH'(ROM_SIZE - 4);

  port_e                    prio_q, prio_d;
  logic                     f_free, d_free;
  logic                     f_elig, d_elig;
  logic                     grant_f, grant_d;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic                     addr_ok;
  logic [ADDRESS_WIDTH-1:0] ld_data;
  logic                     ld_err;

  always_comb begin
    f_elig   = f_req_valid && f_free && !rst;
    d_elig   = d_req_valid && d_free && !rst;
    grant_f  = f_elig && (!d_elig || prio_q == PORT_FETCH);
    grant_d  = d_elig && (!f_elig || prio_q == PORT_DATA);

    prio_d = prio_q;
    if (grant_f) begin
      prio_d = PORT_DATA;
    end else if (grant_d) begin
      prio_d = PORT_FETCH;
    end

    sel_addr = grant_d ? d_req_addr : f_req_addr;
    addr_ok  = (sel_addr >= ROM_BASE) && (sel_addr <= ROM_LAST);
    rom_addr = ((grant_f || grant_d) && addr_ok) ? sel_addr : ROM_BASE;
    ld_data  = addr_ok ? rom_dout : '0;
    ld_err   = !addr_ok;
  end

  // Stage 0 -> 1: round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PORT_FETCH;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign f_req_ready = grant_f;
  assign d_req_ready = grant_d;

  rom_rsp_slot #(
    .DATA_W(ADDRESS_WIDTH)
  ) u_f_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_f),
    .load_data(ld_data),
    .load_err (ld_err),
    .rsp_ready(f_rsp_ready),
    .free     (f_free),
    .rsp_valid(f_rsp_valid),
    .rsp_data (f_rsp_data),
    .rsp_err  (f_rsp_err)
  );

  rom_rsp_slot #(
    .DATA_W(ADDRESS_WIDTH)
  ) u_d_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_d),
    .load_data(ld_data),
    .load_err (ld_err),
    .rsp_ready(d_rsp_ready),
    .free     (d_free),
    .rsp_valid(d_rsp_valid),
    .rsp_data (d_rsp_data),
    .rsp_err  (d_rsp_err)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Table-driven bench for rom_arbiter with a per-port response scoreboard.
module tb_rom_arbiter;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_req_addr, f_rsp_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] d_req_addr, d_rsp_data;
  logic [31:0] rom_addr, rom_dout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        fv;
    logic [31:0] fa;
    logic        frr;
    logic        dv;
    logic [31:0] da;
    logic        drr;
    logic        efr;
    logic        edr;
    logic [31:0] erom;
  } vec_t;

  exp_t fq[$];
  exp_t dq[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == B) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic exp_t exp_rsp(input logic [31:0] a);
    exp_t e;
    logic ok;
    ok     = (a >= B) && (a <= B + 32'h0000_0FFC);
    e.data = ok ? rom_word(a) : 32'h0;
    e.err  = !ok;
    return e;
  endfunction

  assign rom_dout = rom_word(rom_addr);

  rom_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .f_req_valid(f_req_valid),
    .f_req_ready(f_req_ready),
    .f_req_addr (f_req_addr),
    .f_rsp_valid(f_rsp_valid),
    .f_rsp_ready(f_rsp_ready),
    .f_rsp_data (f_rsp_data),
    .f_rsp_err  (f_rsp_err),
    .d_req_valid(d_req_valid),
    .d_req_ready(d_req_ready),
    .d_req_addr (d_req_addr),
    .d_rsp_valid(d_rsp_valid),
    .d_rsp_ready(d_rsp_ready),
    .d_rsp_data (d_rsp_data),
    .d_rsp_err  (d_rsp_err),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: responses expected in request order, one outstanding per port.
  always @(negedge clk) begin
    if (rst) begin
      check("f_ready_in_rst", {31'b0, f_req_ready}, 32'h0);
      check("d_ready_in_rst", {31'b0, d_req_ready}, 32'h0);
      fq.delete();
      dq.delete();
    end else begin
      check("f_rsp_valid", {31'b0, f_rsp_valid}, {31'b0, fq.size() != 0});
      if (fq.size() != 0) begin
        check("f_rsp_data", f_rsp_data, fq[0].data);
        check("f_rsp_err", {31'b0, f_rsp_err}, {31'b0, fq[0].err});
        if (f_rsp_ready) void'(fq.pop_front());
      end
      if (f_req_valid && f_req_ready) fq.push_back(exp_rsp(f_req_addr));

      check("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, dq.size() != 0});
      if (dq.size() != 0) begin
        check("d_rsp_data", d_rsp_data, dq[0].data);
        check("d_rsp_err", {31'b0, d_rsp_err}, {31'b0, dq[0].err});
        if (d_rsp_ready) void'(dq.pop_front());
      end
      if (d_req_valid && d_req_ready) dq.push_back(exp_rsp(d_req_addr));
    end
  end

  task automatic drive(input logic r, input logic fv, input logic [31:0] fa, input logic frr,
                       input logic dv, input logic [31:0] da, input logic drr);
    @(posedge clk);
    #1;
    rst         = r;
    f_req_valid = fv;
    f_req_addr  = fa;
    f_rsp_ready = frr;
    d_req_valid = dv;
    d_req_addr  = da;
    d_rsp_ready = drr;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    f_req_valid = 1'b0; f_req_addr = B; f_rsp_ready = 1'b0;
    d_req_valid = 1'b0; d_req_addr = B; d_rsp_ready = 1'b0;

    //         fv  fa             frr dv  da             drr efr edr erom
    tbl[0]  = '{0, B,             1,  0,  B,             1,  0,  0,  B};
    tbl[1]  = '{1, B,             1,  0,  B,             1,  1,  0,  B};
    tbl[2]  = '{1, B + 32'h4,     1,  1,  B + 32'h8,     1,  0,  1,  B + 32'h8};
    tbl[3]  = '{1, B + 32'h4,     1,  1,  B + 32'h8,     1,  1,  0,  B + 32'h4};
    tbl[4]  = '{1, B + 32'h4,     1,  1,  B + 32'h8,     1,  0,  1,  B + 32'h8};
    tbl[5]  = '{1, B + 32'h4,     1,  1,  B + 32'h8,     1,  1,  0,  B + 32'h4};
    tbl[6]  = '{0, B,             1,  1,  B + 32'hFFD,   1,  0,  1,  B};
    tbl[7]  = '{0, B,             1,  1,  32'h0,         1,  0,  1,  B};
    tbl[8]  = '{0, B,             1,  1,  B + 32'hFFC,   1,  0,  1,  B + 32'hFFC};
    tbl[9]  = '{0, B,             1,  1,  B - 32'h1,     1,  0,  1,  B};
    tbl[10] = '{0, B,             1,  1,  B + 32'h3,     1,  0,  1,  B + 32'h3};
    tbl[11] = '{1, B + 32'h10,    0,  1,  B + 32'h14,    1,  1,  0,  B + 32'h10};
    tbl[12] = '{1, B + 32'h10,    0,  1,  B + 32'h14,    1,  0,  1,  B + 32'h14};
    tbl[13] = '{1, B + 32'h10,    0,  1,  B + 32'h14,    1,  0,  1,  B + 32'h14};
    tbl[14] = '{1, B + 32'h10,    1,  1,  B + 32'h14,    1,  1,  0,  B + 32'h10};
    tbl[15] = '{0, B,             1,  0,  B,             1,  0,  0,  B};
    tbl[16] = '{1, 32'hFFFF_FFFC, 1,  0,  B,             1,  1,  0,  B};
    tbl[17] = '{0, B,             1,  0,  B,             1,  0,  0,  B};

    repeat (3) @(posedge clk);

    drive(0, 0, B, 0, 0, B, 0);
    check("reset_f_valid", {31'b0, f_rsp_valid}, 32'h0);
    check("reset_f_data", f_rsp_data, 32'h0);
    check("reset_f_err", {31'b0, f_rsp_err}, 32'h0);
    check("reset_d_valid", {31'b0, d_rsp_valid}, 32'h0);
    check("reset_d_data", d_rsp_data, 32'h0);
    check("reset_d_err", {31'b0, d_rsp_err}, 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(0, tbl[i].fv, tbl[i].fa, tbl[i].frr, tbl[i].dv, tbl[i].da, tbl[i].drr);
      check($sformatf("v%0d_f_ready", i), {31'b0, f_req_ready}, {31'b0, tbl[i].efr});
      check($sformatf("v%0d_d_ready", i), {31'b0, d_req_ready}, {31'b0, tbl[i].edr});
      check($sformatf("v%0d_rom_addr", i), rom_addr, tbl[i].erom);
    end

    // Fill both slots with consumers stalled, then reset mid-operation.
    drive(0, 1, B + 32'h20, 0, 1, B + 32'h24, 0);
    check("fill_d_ready", {31'b0, d_req_ready}, 32'h1);
    check("fill_f_ready", {31'b0, f_req_ready}, 32'h0);
    drive(0, 1, B + 32'h20, 0, 1, B + 32'h24, 0);
    check("fill2_f_ready", {31'b0, f_req_ready}, 32'h1);
    check("fill2_d_ready", {31'b0, d_req_ready}, 32'h0);
    drive(1, 1, B + 32'h20, 1, 1, B + 32'h24, 1);
    check("rst_f_ready", {31'b0, f_req_ready}, 32'h0);
    check("rst_d_ready", {31'b0, d_req_ready}, 32'h0);
    drive(0, 1, B + 32'h20, 1, 1, B + 32'h24, 1);
    check("post_rst_f_valid", {31'b0, f_rsp_valid}, 32'h0);
    check("post_rst_d_valid", {31'b0, d_rsp_valid}, 32'h0);
    check("post_rst_f_data", f_rsp_data, 32'h0);
    check("post_rst_d_data", d_rsp_data, 32'h0);
    check("post_rst_tie_f", {31'b0, f_req_ready}, 32'h1);
    check("post_rst_tie_d", {31'b0, d_req_ready}, 32'h0);
    drive(0, 1, B + 32'h20, 1, 1, B + 32'h24, 1);
    check("post_rst_next_d", {31'b0, d_req_ready}, 32'h1);
    check("post_rst_next_f", {31'b0, f_req_ready}, 32'h0);
    drive(0, 0, B, 1, 0, B, 1);

    // Single-port streaming: one grant every cycle.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, B + 32'(4 * k), 1, 0, B, 1);
      check($sformatf("stream%0d_f_ready", k), {31'b0, f_req_ready}, 32'h1);
      check($sformatf("stream%0d_rom_addr", k), rom_addr, B + 32'(4 * k));
    end
    drive(0, 0, B, 1, 0, B, 1);
    drive(0, 0, B, 1, 0, B, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single combinational read port of the boot/instruction ROM (byte-addressed, 32-bit little-endian word read, 0xBFC00000–0xBFC00FFF) between the instruction-fetch path and the data-load path. It accepts at most one request per cycle, registers the ROM word into a per-port one-entry response slot, and flags accesses whose four bytes fall outside the ROM window. It sits between the fetch/LSU requesters and the ROM.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of request addresses, ROM address and data words
- ROM_BASE, 32'hBFC00000, lowest ROM byte address
- ROM_SIZE, 4096, ROM size in bytes

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle when high with valid
- f_req_addr  in  ADDRESS_WIDTH  fetch byte address
- f_rsp_valid  out  1  fetch response held in slot
- f_rsp_ready  in  1  fetch consumer takes response
- f_rsp_data  out  ADDRESS_WIDTH  fetched word
- f_rsp_err  out  1  fetch address out of range
- d_req_valid, d_req_ready, d_req_addr, d_rsp_valid, d_rsp_ready, d_rsp_data, d_rsp_err: same as f_*, for the data port
- rom_addr  out  ADDRESS_WIDTH  address driven to ROM
- rom_dout  in  ADDRESS_WIDTH  combinational ROM word for rom_addr

## Operation
- Port p is eligible when p_req_valid=1 and its slot is free: slot empty, or slot full with p_rsp_ready=1 this cycle (pass-through).
- Grant: one eligible port → grant it. Both eligible → round-robin: grant the port not granted last (prio pointer). Pointer updates only on an actual grant.
- p_req_ready = grant_p (combinational from valid, slot state, rsp_ready, pointer). A port never sees ready without being granted.
- Range check: ok = (addr ≥ ROM_BASE) && (addr ≤ ROM_BASE+ROM_SIZE-4), compared in ADDRESS_WIDTH unsigned arithmetic; no wrap. Misaligned in-range addresses are legal (ROM assembles bytes).
- rom_addr = granted port's addr if ok, else ROM_BASE (never drive out-of-window address). No grant → rom_addr = ROM_BASE.
- On grant: slot loads data = ok ? rom_dout : 0, err = !ok, valid=1.
- Slot clears when rsp_valid && rsp_ready and no new grant to that port same cycle; simultaneous drain+grant overwrites with new response, valid stays 1.
- Responses per port are returned in request order (one outstanding max per port).

## Timing
- Reset: f/d_rsp_valid=0, rsp_data=0, rsp_err=0, prio pointer favours fetch on first tie; req_ready follows combinationally (0 with no valid).
- Latency: request accepted cycle N → p_rsp_valid=1 in cycle N+1 with data.
- Throughput: one grant per cycle total; a single port with rsp_ready held high streams one response per cycle.
- rsp_data/rsp_err stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: buffered responses dropped, no partial state retained; requests presented during rst cycle are not accepted (req_ready=0 while rst=1).
- Requester must hold req_addr stable while req_valid=1 and ready=0.

## Structure
- Shared package rom_pkg: ROM_BASE, ROM_SIZE constants, port index enum (PORT_FETCH, PORT_DATA), response struct {data, err}.
- One sub-module: rom_rsp_slot (one-entry valid/ready response register with pass-through load), instantiated per port.
- Arbitration, range check and ROM address mux live in rom_arbiter.

## Test plan
- Fetch only, addr 0xBFC00000, rom word 0x00500093, rsp_ready=1 → f_req_ready=1 cycle N, f_rsp_valid=1, data 0x00500093, err=0 at N+1.
- Both valid every cycle, both rsp_ready=1 → grants alternate F,D,F,D starting with F after reset; each port one response per two cycles.
- Data addr 0xBFC00FFD (last 3 bytes) and 0x00000000 → d_rsp_err=1, d_rsp_data=0, rom_addr=0xBFC00000; addr 0xBFC00FFC → err=0.
- f_rsp_ready=0 with slot full → f_req_ready=0, d port still granted each cycle; raise f_rsp_ready → same-cycle pass-through grant, f_rsp_valid stays 1 with new data.
- Assert rst while both slots valid → next cycle both rsp_valid=0, data 0; first post-reset tie granted to fetch.
